// File: rtl/clk_div_pkg.sv
// Shared constants for the programmable clock divider family.
package clk_div_pkg;

  localparam int unsigned CLK_HZ    = 50_000_000;
  localparam int unsigned DIV_1HZ   = CLK_HZ;
  localparam int unsigned DIV_100HZ = CLK_HZ / 100;
  localparam int unsigned DIV_1KHZ  = CLK_HZ / 1000;
  localparam int unsigned MIN_DIV   = 2;

endpackage

// File: rtl/div_shadow_reg.sv
// Shadow register for the divisor: captures (clamped) new values and
// signals when a pending value should be transferred to the active divisor.
module div_shadow_reg
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH = 26
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_div_in,
  input  logic             i_div_load,
  input  logic             i_apply_req,
  output logic [WIDTH-1:0] o_div_pend,
  output logic             o_div_busy,
  output logic             o_apply
);

  logic [WIDTH-1:0] r_pend;
  logic             r_busy;
  logic [WIDTH-1:0] w_clamped;

  assign w_clamped  = (i_div_in < WIDTH'(MIN_DIV)) ? WIDTH'(MIN_DIV) : i_div_in;
  assign o_apply    = r_busy & i_apply_req;
  assign o_div_pend = r_pend;
  assign o_div_busy = r_busy;

  // A fresh load always wins over a same-cycle apply, so busy stays set and
  // the old pending value is what the apply transfers on this edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend <= '0;
      r_busy <= 1'b0;
    end else if (i_div_load) begin
      r_pend <= w_clamped;
      r_busy <= 1'b1;
    end else if (o_apply) begin
      r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// Programmable synchronous divider: one-cycle tick and near-50% square wave
// every div_act enabled cycles; divisor changes take effect on period bounds.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH       = 26,
  parameter int unsigned DEFAULT_DIV = DIV_1HZ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_busy,
  output logic             tick,
  output logic             sq_out,
  output logic [WIDTH-1:0] cnt_out
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_div_act;
  logic             r_tick;
  logic             r_sq;

  logic [WIDTH-1:0] w_cnt_next;
  logic [WIDTH-1:0] w_div_pend;
  logic [WIDTH-1:0] w_high_len;
  logic             w_wrap;
  logic             w_apply;

  assign w_wrap     = en & ~clr & (r_cnt == r_div_act - WIDTH'(1));
  assign w_cnt_next = w_wrap ? '0 : r_cnt + WIDTH'(1);
  // ceil(N/2): the high phase gets the extra cycle for odd divisors
  assign w_high_len = r_div_act - (r_div_act >> 1);

  div_shadow_reg #(
    .WIDTH(WIDTH)
  ) u_shadow (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_div_in   (div_in),
    .i_div_load (div_load),
    .i_apply_req(w_wrap | clr),
    .o_div_pend (w_div_pend),
    .o_div_busy (div_busy),
    .o_apply    (w_apply)
  );

  // Period counter with synchronous clear and enable-gated wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_cnt_next;
    end
  end

  // Active divisor is only replaced on a wrap or clear, keeping periods whole.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_act <= WIDTH'(DEFAULT_DIV);
    end else if (w_apply) begin
      r_div_act <= w_div_pend;
    end
  end

  // Registered tick and square wave; after a wrap the next count is 0, which
  // is always in the high phase, so the old divisor gives the right level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick <= 1'b0;
      r_sq   <= 1'b0;
    end else if (clr) begin
      r_tick <= 1'b0;
      r_sq   <= 1'b0;
    end else begin
      r_tick <= w_wrap;
      if (en) begin
        r_sq <= (w_cnt_next < w_high_len);
      end
    end
  end

  assign tick    = r_tick;
  assign sq_out  = r_sq;
  assign cnt_out = r_cnt;

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog (WIDTH=8, DEFAULT_DIV=4).
module tb_clk_div_prog;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] div_in = '0;
  logic         div_load = 1'b0;
  logic         div_busy;
  logic         tick;
  logic         sq_out;
  logic [W-1:0] cnt_out;

  clk_div_prog #(
    .WIDTH      (W),
    .DEFAULT_DIV(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .clr     (clr),
    .div_in  (div_in),
    .div_load(div_load),
    .div_busy(div_busy),
    .tick    (tick),
    .sq_out  (sq_out),
    .cnt_out (cnt_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   seq;
    logic tick;
    logic sq;
    int   cnt;
    logic busy;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   seq_no   = 0;

  // Reference model: position inside the current period and period lengths.
  int   m_pos, m_period, m_pend;
  logic m_busy, m_tick, m_sq;

  task automatic model_reset();
    m_pos = 0; m_period = 4; m_pend = 0;
    m_busy = 0; m_tick = 0; m_sq = 0;
  endtask

  task automatic model_edge(input logic e, input logic c, input logic ld, input int din);
    m_tick = 0;
    if (c) begin
      m_pos = 0;
      m_sq  = 0;
      if (m_busy) begin m_period = m_pend; m_busy = 0; end
    end else if (e) begin
      if (m_pos + 1 == m_period) begin
        m_pos  = 0;
        m_tick = 1;
        if (m_busy) begin m_period = m_pend; m_busy = 0; end
      end else begin
        m_pos = m_pos + 1;
      end
      // high for ceil(N/2) of the N positions in the period
      m_sq = (m_pos < (m_period + 1) / 2);
    end
    if (ld) begin
      m_pend = (din < 2) ? 2 : din;
      m_busy = 1;
    end
  endtask

  task automatic push_exp();
    exp_t x;
    x.seq = seq_no; x.tick = m_tick; x.sq = m_sq; x.cnt = m_pos; x.busy = m_busy;
    seq_no++;
    q.push_back(x);
  endtask

  task automatic step(input logic e, input logic c, input logic ld, input int din);
    @(negedge clk);
    rst = 0; en = e; clr = c; div_load = ld; div_in = W'(din);
    model_edge(e, c, ld, din);
    push_exp();
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst = 1; en = 0; clr = 0; div_load = 0; div_in = '0;
    model_reset();
    push_exp();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0);
  endtask

  task automatic run_to_pos(input int p);
    for (int i = 0; i < 200 && m_pos != p; i++) step(1, 0, 0, 0);
  endtask

  // Monitor: compares DUT outputs after every clock edge that has an expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        n_checks++;
        if (tick === x.tick && sq_out === x.sq && int'(cnt_out) == x.cnt && div_busy === x.busy
            && !$isunknown(cnt_out)) begin
          n_pass++;
        end else begin
          $display("FAIL edge_%0d: got tick=%b sq=%b cnt=%0d busy=%b, want tick=%b sq=%b cnt=%0d busy=%b",
                   x.seq, tick, sq_out, cnt_out, div_busy, x.tick, x.sq, x.cnt, x.busy);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    hold_reset();
    hold_reset();

    // Default divisor 4: ticks on edges 4, 8, 12
    run(12);

    // Divisor 5 via load at a period start
    run_to_pos(0);
    step(1, 0, 1, 5);
    run(15);

    // Load 3 mid-period: current period finishes at its old length
    run_to_pos(1);
    step(1, 0, 1, 3);
    run(12);

    // Values 0 and 1 clamp to 2
    step(1, 0, 1, 0);
    step(1, 0, 1, 1);
    run(10);

    // Freeze at count 2 for 7 cycles
    step(1, 0, 1, 5);
    run(8);
    run_to_pos(2);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0);
    run(6);

    // Pending 6 applied immediately by clear
    step(1, 0, 1, 6);
    run_to_pos(3);
    step(1, 1, 0, 0);
    run(14);

    // Clear and load in the same cycle, then load on the wrap cycle
    step(1, 0, 1, 3);
    step(1, 1, 1, 7);
    run_to_pos(6);
    step(1, 0, 1, 4);
    run(10);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 19) == 0), int'($urandom_range(0, 12)));
    end

    // Asynchronous reset mid-cycle with a pending divisor and nonzero count
    step(1, 0, 1, 9);
    run_to_pos(2);
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    n_checks++;
    if (tick === 1'b0 && sq_out === 1'b0 && cnt_out === '0 && div_busy === 1'b0) begin
      n_pass++;
    end else begin
      $display("FAIL async_rst: got tick=%b sq=%b cnt=%0d busy=%b, want all 0",
               tick, sq_out, cnt_out, div_busy);
    end
    hold_reset();
    run(9);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: got %0d expectations left, want 0", q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
Parametrised, fully synchronous programmable frequency divider. It is the successor to the cascaded-toggle-flip-flop divider, which only divides by powers of two and whose stages ripple asynchronously. This block divides by any integer N ≥ 2 at runtime. It produces a one-cycle enable pulse (tick) and a near-50% square wave, both registered and glitch-free. It sits between the board clock and the slow-rate logic (display refresh, seconds counters, debounce sampling).

Parameters:
WIDTH, 26, counter/divisor width in bits (2^26 > 50_000_000)
DEFAULT_DIV, 50_000_000, divisor loaded at reset; must be ≥2 and < 2^WIDTH

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  count enable; low freezes the counter and outputs, and forces tick=0
clr  in  1  synchronous clear of the period; also applies any pending divisor immediately
div_in  in  WIDTH  new divisor value N
div_load  in  1  single-cycle strobe capturing div_in into the pending register
div_busy  out  1  high while a captured divisor waits to be applied
tick  out  1  one-cycle pulse, once per N enabled cycles
sq_out  out  1  square wave of period N enabled cycles
cnt_out  out  WIDTH  current counter value (debug/observation)

Behaviour:
- Reset (async, rst=1):
  - cnt=0, div_act=DEFAULT_DIV, div_pend=0.
  - div_busy=0, tick=0, sq_out=0.
- Divisor capture:
  - On div_load=1, div_pend <= max(div_in, 2) and div_busy <= 1.
  - Values 0 and 1 are clamped to 2.
  - Capture happens regardless of en.
- Load while busy: the new value overwrites div_pend ("last wins"); div_busy stays 1.
- Counting:
  - When en=1, cnt increments each cycle over 0..div_act-1.
  - The wrap condition is cnt==div_act-1 with en=1; on wrap, cnt <= 0.
- Pending divisor application:
  - On wrap with div_busy=1: div_act <= div_pend, and div_busy <= 0 on the same edge.
  - The new period starts from cnt=0, so there is never a truncated or over-long period.
- tick (registered):
  - tick <= 1 on the wrap edge, 0 otherwise.
  - tick is therefore high for exactly one cycle, in the cycle where cnt_out==0 after a wrap.
- sq_out (registered, derived from next count value c'):
  - sq_out <= (c' < N - floor(N/2)), with N = div_act in force for that period.
  - High for ceil(N/2) cycles, low for floor(N/2) cycles.
  - Rising edge coincides with tick.
- en=0: cnt, sq_out, div_act and div_busy hold; tick <= 0. Pending divisor is not applied until a wrap.
- clr=1:
  - cnt <= 0, tick <= 0, sq_out <= 0.
  - If div_busy, div_act <= div_pend and div_busy <= 0.
  - clr acts regardless of en.
- Priority: rst > clr > div_load capture/en counting.
- clr and div_load in the same cycle: the clr applies the old div_pend, then div_load captures the new value; div_busy ends at 1.
- div_load on the wrap cycle: wrap applies the old div_pend; the new value is captured and div_busy=1.
- Reset mid-period: all state returns immediately to reset values; the pending divisor is lost.
- Latency:
  - First tick after reset with en=1 constantly: at cycle N (the N-th rising edge after rst deasserts).
  - Subsequent ticks every N cycles.
- Arithmetic: unsigned WIDTH bits; comparisons against div_act-1 never overflow, since div_act ≥ 2.

Decomposition:
- Shared package clk_div_pkg:
  - CLK_HZ = 50_000_000.
  - Standard divisor constants: DIV_1HZ, DIV_1KHZ, DIV_100HZ.
  - MIN_DIV = 2.
- One sub-module, div_shadow_reg: holds div_pend, div_busy and the clamp logic, and exposes an apply strobe.
- The counter, tick and sq_out logic stays in clk_div_prog.

Test Plan:
1. WIDTH=8, DEFAULT_DIV=4; release rst, en=1 → tick high on cycles 4, 8, 12; sq_out pattern 1,1,0,0 repeating; cnt_out 0,1,2,3.
2. DEFAULT_DIV=5 → sq_out high 3 cycles and low 2 cycles; tick every 5 cycles.
3. Mid-period (cnt=1), div_load with div_in=3 → div_busy=1 until the next wrap; that period completes at length 4; following ticks are 3 cycles apart; div_busy drops at the wrap.
4. div_load div_in=0, then div_in=1 → div_act becomes 2 after the wrap; tick every 2 cycles; sq_out alternates 1,0.
5. en low for 7 cycles at cnt=2 → cnt_out holds at 2, tick stays 0, sq_out holds; after re-enable, tick arrives 2 enabled cycles later.
6. div_in=6 pending, then clr pulse at cnt=3 → next edge gives cnt=0 and div_busy=0; tick 6 cycles later. Separately, assert rst asynchronously mid-clock-cycle → outputs drop to 0 without waiting for a clk edge.
